axis_mux_sched: RTL and testbench
=================================

AXIS_MUX_SCHED -- requirements
Module: axis_mux_sched

Interface
REQ-001 Parameter S_COUNT, default 4: number of mux inputs to schedule, range 2..16.
REQ-002 Parameter WEIGHT_WIDTH, default 4: width of each per-port frame quota.
REQ-003 Port clk, input, 1: sole clock; all logic rises on posedge clk.
REQ-004 Port rst_n, input, 1: reset, asynchronous assert, active-low, synchronous deassert handled upstream.
REQ-005 Port s_axis_tvalid, input, S_COUNT: request vector, tapped from the mux input tvalid lines.
REQ-006 Port m_axis_tvalid / m_axis_tready / m_axis_tlast, input, 1 each: mux output handshake monitor.
REQ-007 Port cfg_weight, input, S_COUNT*WEIGHT_WIDTH: per-port frames per grant; 0 = port excluded.
REQ-008 Port ctrl_enable, input, 1: global scheduling enable.
REQ-009 Port enable, output, 1: drives the mux enable; registered.
REQ-010 Port sel, output, $clog2(S_COUNT): drives the mux select; registered.
REQ-011 Port grant_active, output, 1: high while in ACTIVE.

Function
REQ-012 The block SHALL implement states IDLE, ARB, ACTIVE, DRAIN.
REQ-013 IDLE: enable=0; go to ARB when ctrl_enable=1 and any eligible request exists (tvalid=1 and weight!=0).
REQ-014 ARB (exactly 1 cycle): round-robin pick, starting at last granted port+1 and wrapping at S_COUNT-1 -> 0; register sel, latch that port's weight into quota counter, set last_grant; next ACTIVE with enable=1.
REQ-015 ARB with no eligible request (requests dropped) SHALL return to IDLE, sel unchanged.
REQ-016 in_frame flag: set on output beat (tvalid&tready) with tlast=0, cleared on beat with tlast=1.
REQ-017 ACTIVE: each tlast beat decrements quota; the beat taking quota to 0 SHALL transition to ARB with enable=0 on the next cycle.
REQ-018 ACTIVE with in_frame=0, no beat this cycle and selected tvalid=0 SHALL release to ARB (enable=0 next cycle).
REQ-019 ACTIVE with ctrl_enable=0: in_frame=0 -> IDLE immediately; in_frame=1 -> DRAIN.
REQ-020 DRAIN: enable=0, sel held; on tlast beat -> IDLE.
REQ-021 sel SHALL never change while in_frame=1 or enable=1.
REQ-022 Latency: first request in IDLE -> enable=1 exactly 2 cycles later.
REQ-023 cfg_weight SHALL be sampled only in ARB; mid-grant changes take effect at the next grant.
REQ-024 Single eligible port: re-granted each ARB; one idle cycle (enable=0) per quota exhaustion.
REQ-025 Simultaneous tlast quota exhaustion and ctrl_enable fall: IDLE wins.

Reset
REQ-026 On rst_n=0: state=IDLE, enable=0, sel=0, grant_active=0, last_grant=S_COUNT-1 (port 0 served first), quota=0, in_frame=0.
REQ-027 Reset mid-frame SHALL drop enable immediately; recovery of the mux's own frame state is the integrator's concern.

Structure
REQ-028 State encodings and quota width SHALL be module-local localparams; no shared package is required.
REQ-029 Round-robin selection SHALL be a combinational sub-module arb_rr_pick (inputs request mask and last grant, outputs valid and index).

Verification
REQ-030 Reset, tvalid=4'b0101, all weights=1 -> port 0 granted (sel=0, enable high at cycle 2), then port 2, then port 0.
REQ-031 Weights {3,1,1,1}, all requesting, single-beat frames -> grant order 0,0,0,1,2,3,0; sel stable during each grant.
REQ-032 3-beat frame on port 1, ctrl_enable dropped at beat 2 -> DRAIN, frame completes, IDLE, enable=0, sel=1 held.
REQ-033 cfg_weight port 2 = 0, tvalid=4'b0100 -> stays IDLE, enable never asserts.
REQ-034 Port 3 granted, deasserts tvalid between frames with quota left -> enable=0 next cycle, ARB grants port 0.
REQ-035 rst_n asserted mid-frame in ACTIVE -> enable=0 same cycle, all outputs at reset values.

Source files
------------

// File: rtl/arb_rr_pick.sv
// Combinational round-robin picker: scans the request mask starting one past
// the last granted index, wrapping from N-1 back to 0.
module arb_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          valid,
    output logic [IW-1:0] idx
);

    always_comb begin
        int          p;
        logic [IW-1:0] pi;
        valid = 1'b0;
        idx   = last;
        p     = 0;
        pi    = '0;
        // Walk from farthest to nearest so the nearest requester is written last.
        for (int i = N; i >= 1; i--) begin
            p  = (int'(last) + i) % N;
            pi = IW'(p);
            if (req[pi]) begin
                valid = 1'b1;
                idx   = pi;
            end
        end
    end

endmodule

// File: rtl/axis_mux_sched.sv
// Weighted round-robin scheduler driving an AXI-Stream mux's enable/select,
// granting whole frames per port up to a per-port quota.
module axis_mux_sched #(
    parameter int S_COUNT      = 4,
    parameter int WEIGHT_WIDTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [S_COUNT-1:0]              s_axis_tvalid,
    input  logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    input  logic                            m_axis_tlast,
    input  logic [S_COUNT*WEIGHT_WIDTH-1:0] cfg_weight,
    input  logic                            ctrl_enable,
    output logic                            enable,
    output logic [$clog2(S_COUNT)-1:0]      sel,
    output logic                            grant_active
);

    localparam int SEL_W   = $clog2(S_COUNT);
    localparam int QUOTA_W = WEIGHT_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARB    = 2'd1,
        ACTIVE = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t             state, next_state;
    logic [QUOTA_W-1:0] quota;
    logic [SEL_W-1:0]   last_grant;
    logic               in_frame;

    logic [WEIGHT_WIDTH-1:0] weights [S_COUNT];
    logic [S_COUNT-1:0]      eligible;
    logic                    pick_valid;
    logic [SEL_W-1:0]        pick_idx;
    logic                    beat;
    logic                    frame_open;
    logic                    grant_load;
    logic                    quota_dec;

    always_comb begin
        for (int i = 0; i < S_COUNT; i++) begin
            weights[i]  = cfg_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            eligible[i] = s_axis_tvalid[i] && (weights[i] != '0);
        end
    end

    arb_rr_pick #(
        .N  (S_COUNT),
        .IW (SEL_W)
    ) u_pick (
        .req   (eligible),
        .last  (last_grant),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign beat = m_axis_tvalid && m_axis_tready;
    // Frame state as it will stand after this cycle's beat, if any.
    assign frame_open   = beat ? !m_axis_tlast : in_frame;
    assign grant_active = (state == ACTIVE);

    always_comb begin
        next_state = state;
        grant_load = 1'b0;
        quota_dec  = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl_enable && (|eligible) && !in_frame)
                    next_state = ARB;
            end
            ARB: begin
                if (ctrl_enable && pick_valid) begin
                    grant_load = 1'b1;
                    next_state = ACTIVE;
                end else begin
                    next_state = IDLE;
                end
            end
            ACTIVE: begin
                // Disable takes priority over quota exhaustion.
                if (!ctrl_enable) begin
                    next_state = frame_open ? DRAIN : IDLE;
                end else if (beat && m_axis_tlast) begin
                    quota_dec = 1'b1;
                    if (quota <= QUOTA_W'(1))
                        next_state = ARB;
                end else if (!in_frame && !beat && !s_axis_tvalid[sel]) begin
                    next_state = ARB;
                end
            end
            DRAIN: begin
                if (beat && m_axis_tlast)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            enable     <= 1'b0;
            sel        <= '0;
            last_grant <= SEL_W'(S_COUNT - 1);
            quota      <= '0;
            in_frame   <= 1'b0;
        end else begin
            state    <= next_state;
            enable   <= (next_state == ACTIVE);
            in_frame <= frame_open;
            if (grant_load) begin
                sel        <= pick_idx;
                last_grant <= pick_idx;
                quota      <= weights[pick_idx];
            end else if (quota_dec) begin
                quota <= quota - QUOTA_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_axis_mux_sched.sv
// Vector-table bench for axis_mux_sched with a scoreboard of expected outputs.
module tb_axis_mux_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  s_axis_tvalid = '0;
    logic        m_axis_tvalid = 1'b0;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tlast = 1'b0;
    logic [15:0] cfg_weight = '0;
    logic        ctrl_enable = 1'b0;
    logic        enable;
    logic [1:0]  sel;
    logic        grant_active;

    int n_cmp = 0;
    int n_bad = 0;

    axis_mux_sched #(
        .S_COUNT      (4),
        .WEIGHT_WIDTH (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tvalid (s_axis_tvalid),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .cfg_weight    (cfg_weight),
        .ctrl_enable   (ctrl_enable),
        .enable        (enable),
        .sel           (sel),
        .grant_active  (grant_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        bit          rst;
        logic [3:0]  tv;
        bit          bt;
        bit          ml;
        bit          ce;
        logic [15:0] w;
        bit          en;
        logic [1:0]  sel;
        bit          ga;
    } vec_t;

    typedef struct {
        string      tag;
        bit         en;
        logic [1:0] sel;
        bit         ga;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(string tag, bit rst, logic [3:0] tv, bit bt, bit ml,
                                bit ce, logic [15:0] w, bit en, logic [1:0] s, bit ga);
        vec_t v;
        v.tag = tag; v.rst = rst; v.tv = tv; v.bt = bt; v.ml = ml;
        v.ce = ce; v.w = w; v.en = en; v.sel = s; v.ga = ga;
        return v;
    endfunction

    task automatic check(string tag, bit en, logic [1:0] s, bit ga);
        n_cmp++;
        if (enable !== en || sel !== s || grant_active !== ga) begin
            n_bad++;
            $display("FAIL %s: got en=%0b sel=%0d ga=%0b, expected en=%0b sel=%0d ga=%0b",
                     tag, enable, sel, grant_active, en, s, ga);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        s_axis_tvalid = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        m_axis_tlast  = 1'b0;
        ctrl_enable   = 1'b0;
        cfg_weight    = '0;
        @(posedge clk);
        #1;
        check("reset", 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic apply(vec_t v);
        exp_t e;
        @(negedge clk);
        s_axis_tvalid = v.tv;
        m_axis_tvalid = v.bt;
        m_axis_tready = v.bt;
        m_axis_tlast  = v.ml;
        ctrl_enable   = v.ce;
        cfg_weight    = v.w;
        sb.push_back('{tag: v.tag, en: v.en, sel: v.sel, ga: v.ga});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: scoreboard empty, got en=%0b, expected an entry", v.tag, enable);
        end else begin
            e = sb.pop_front();
            check(e.tag, e.en, e.sel, e.ga);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Two ports requesting, unit weights: 0, 2, 0 with one ARB cycle between grants.
        vecs.push_back(mk("rr_arb",     1, 4'b0101, 0, 0, 1, 16'h1111, 0, 2'd0, 0));
        vecs.push_back(mk("rr_g0",      0, 4'b0101, 0, 0, 1, 16'h1111, 1, 2'd0, 1));
        vecs.push_back(mk("rr_g0_end",  0, 4'b0101, 1, 1, 1, 16'h1111, 0, 2'd0, 0));
        vecs.push_back(mk("rr_g2",      0, 4'b0101, 0, 0, 1, 16'h1111, 1, 2'd2, 1));
        vecs.push_back(mk("rr_g2_end",  0, 4'b0101, 1, 1, 1, 16'h1111, 0, 2'd2, 0));
        vecs.push_back(mk("rr_g0_again",0, 4'b0101, 0, 0, 1, 16'h1111, 1, 2'd0, 1));
        // Weights {3,1,1,1}: port 0 carries three frames, then 1, 2, 3, 0.
        vecs.push_back(mk("wt_arb",     1, 4'b1111, 0, 0, 1, 16'h1113, 0, 2'd0, 0));
        vecs.push_back(mk("wt_g0",      0, 4'b1111, 0, 0, 1, 16'h1113, 1, 2'd0, 1));
        vecs.push_back(mk("wt_g0_f1",   0, 4'b1111, 1, 1, 1, 16'h1113, 1, 2'd0, 1));
        vecs.push_back(mk("wt_g0_f2",   0, 4'b1111, 1, 1, 1, 16'h1113, 1, 2'd0, 1));
        vecs.push_back(mk("wt_g0_f3",   0, 4'b1111, 1, 1, 1, 16'h1113, 0, 2'd0, 0));
        vecs.push_back(mk("wt_g1",      0, 4'b1111, 0, 0, 1, 16'h1113, 1, 2'd1, 1));
        vecs.push_back(mk("wt_g1_end",  0, 4'b1111, 1, 1, 1, 16'h1113, 0, 2'd1, 0));
        vecs.push_back(mk("wt_g2",      0, 4'b1111, 0, 0, 1, 16'h1113, 1, 2'd2, 1));
        vecs.push_back(mk("wt_g2_end",  0, 4'b1111, 1, 1, 1, 16'h1113, 0, 2'd2, 0));
        vecs.push_back(mk("wt_g3",      0, 4'b1111, 0, 0, 1, 16'h1113, 1, 2'd3, 1));
        vecs.push_back(mk("wt_g3_end",  0, 4'b1111, 1, 1, 1, 16'h1113, 0, 2'd3, 0));
        vecs.push_back(mk("wt_g0_wrap", 0, 4'b1111, 0, 0, 1, 16'h1113, 1, 2'd0, 1));
        // Port 1 three-beat frame, disable at beat 2: drain, then idle with sel held.
        vecs.push_back(mk("dr_arb",     1, 4'b0010, 0, 0, 1, 16'h2222, 0, 2'd0, 0));
        vecs.push_back(mk("dr_g1",      0, 4'b0010, 0, 0, 1, 16'h2222, 1, 2'd1, 1));
        vecs.push_back(mk("dr_beat1",   0, 4'b0010, 1, 0, 1, 16'h2222, 1, 2'd1, 1));
        vecs.push_back(mk("dr_beat2",   0, 4'b0010, 1, 0, 0, 16'h2222, 0, 2'd1, 0));
        vecs.push_back(mk("dr_wait",    0, 4'b0010, 0, 0, 0, 16'h2222, 0, 2'd1, 0));
        vecs.push_back(mk("dr_beat3",   0, 4'b0010, 1, 1, 0, 16'h2222, 0, 2'd1, 0));
        vecs.push_back(mk("dr_idle",    0, 4'b0010, 0, 0, 0, 16'h2222, 0, 2'd1, 0));
        vecs.push_back(mk("dr_rearb",   0, 4'b0010, 0, 0, 1, 16'h2222, 0, 2'd1, 0));
        vecs.push_back(mk("dr_regrant", 0, 4'b0010, 0, 0, 1, 16'h2222, 1, 2'd1, 1));
        // Zero weight excludes the only requesting port.
        vecs.push_back(mk("zw_c1",      1, 4'b0100, 0, 0, 1, 16'h1011, 0, 2'd0, 0));
        vecs.push_back(mk("zw_c2",      0, 4'b0100, 0, 0, 1, 16'h1011, 0, 2'd0, 0));
        vecs.push_back(mk("zw_c3",      0, 4'b0100, 0, 0, 1, 16'h1011, 0, 2'd0, 0));
        vecs.push_back(mk("zw_c4",      0, 4'b0100, 0, 0, 1, 16'h1011, 0, 2'd0, 0));
        // Port 3 releases early with quota left; then quota-out and disable coincide.
        vecs.push_back(mk("rl_arb",     1, 4'b1000, 0, 0, 1, 16'h2222, 0, 2'd0, 0));
        vecs.push_back(mk("rl_g3",      0, 4'b1000, 0, 0, 1, 16'h2222, 1, 2'd3, 1));
        vecs.push_back(mk("rl_g3_f1",   0, 4'b1000, 1, 1, 1, 16'h2222, 1, 2'd3, 1));
        vecs.push_back(mk("rl_release", 0, 4'b0001, 0, 0, 1, 16'h2222, 0, 2'd3, 0));
        vecs.push_back(mk("rl_g0",      0, 4'b0001, 0, 0, 1, 16'h2222, 1, 2'd0, 1));
        vecs.push_back(mk("rl_g0_f1",   0, 4'b0001, 1, 1, 1, 16'h2222, 1, 2'd0, 1));
        vecs.push_back(mk("rl_g0_off",  0, 4'b0001, 1, 1, 0, 16'h2222, 0, 2'd0, 0));
        vecs.push_back(mk("rl_idle",    0, 4'b0001, 0, 0, 0, 16'h2222, 0, 2'd0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst)
                do_reset();
            apply(vecs[i]);
        end

        // Reset asserted mid-frame must clear outputs without waiting for a clock edge.
        do_reset();
        apply(mk("mr_arb",   0, 4'b0010, 0, 0, 1, 16'h2222, 0, 2'd0, 0));
        apply(mk("mr_g1",    0, 4'b0010, 0, 0, 1, 16'h2222, 1, 2'd1, 1));
        apply(mk("mr_beat1", 0, 4'b0010, 1, 0, 1, 16'h2222, 1, 2'd1, 1));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_async_reset", 1'b0, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        check("mr_reset_held", 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
